// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit 7-segment scanner: one digit per slot with leading dead time,
// frame-latched input word and registered segment/anode outputs.
module seven_seg_scanner #(
  parameter int DIGIT_CYCLES    = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int AN_ACTIVE_LOW   = 1,
  parameter int LEAD_ZERO_BLANK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF    = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]    AN_OFF    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  // Active-high hex decode, bit order g..a
  function automatic logic [6:0] decode_nibble(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Bit k set means digit k is a leading zero; digit 0 always shows
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] && (d[11:8] == 4'h0);
    m[1] = m[2] && (d[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  logic [CW-1:0] cyc_r, cyc_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [15:0]   shadow_d_r, shadow_d_nxt_s;
  logic [3:0]    shadow_dp_r, shadow_dp_nxt_s;
  logic          latch_s, drive_s;
  logic [3:0]    blank_mask_s;
  logic [3:0]    nibble_s;
  logic [6:0]    seg_r, seg_nxt_s;
  logic          dp_r, dp_nxt_s;
  logic [3:0]    an_r, an_nxt_s;
  logic          frame_start_r;

  // Next scan position, frame latch and the output values for that position
  always_comb begin
    cyc_nxt_s       = cyc_r;
    idx_nxt_s       = idx_r;
    shadow_d_nxt_s  = shadow_d_r;
    shadow_dp_nxt_s = shadow_dp_r;
    an_nxt_s        = AN_OFF;
    seg_nxt_s       = SEG_OFF;
    dp_nxt_s        = DP_OFF;
    blank_mask_s    = 4'b0000;

    latch_s = (idx_r == 2'd3) && (cyc_r == CYC_LAST);

    if (cyc_r == CYC_LAST) begin
      cyc_nxt_s = {CW{1'b0}};
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      cyc_nxt_s = cyc_r + CW'(1);
      idx_nxt_s = idx_r;
    end

    if (latch_s) begin
      shadow_d_nxt_s  = digits_in;
      shadow_dp_nxt_s = dp_in;
    end else begin
      shadow_d_nxt_s  = shadow_d_r;
      shadow_dp_nxt_s = shadow_dp_r;
    end

    if (LEAD_ZERO_BLANK != 0) begin
      blank_mask_s = lead_zero_mask(shadow_d_nxt_s);
    end else begin
      blank_mask_s = 4'b0000;
    end

    nibble_s = shadow_d_nxt_s[{idx_nxt_s, 2'b00} +: 4];
    drive_s  = enable && (cyc_nxt_s >= BLANK_END) && !blank_mask_s[idx_nxt_s];

    // Outputs are computed from next-state so they line up with idx/cyc in the same cycle
    if (drive_s) begin
      an_nxt_s  = AN_OFF ^ (4'b0001 << idx_nxt_s);
      seg_nxt_s = decode_nibble(nibble_s) ^ SEG_OFF;
      dp_nxt_s  = shadow_dp_nxt_s[idx_nxt_s] ^ DP_OFF;
    end else begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = DP_OFF;
    end
  end

  // Scan counters, frame shadows and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_r         <= CYC_LAST;
      idx_r         <= 2'd3;
      shadow_d_r    <= 16'h0000;
      shadow_dp_r   <= 4'h0;
      frame_start_r <= 1'b0;
      an_r          <= AN_OFF;
      seg_r         <= SEG_OFF;
      dp_r          <= DP_OFF;
    end else begin
      cyc_r         <= cyc_nxt_s;
      idx_r         <= idx_nxt_s;
      shadow_d_r    <= shadow_d_nxt_s;
      shadow_dp_r   <= shadow_dp_nxt_s;
      frame_start_r <= latch_s;
      an_r          <= an_nxt_s;
      seg_r         <= seg_nxt_s;
      dp_r          <= dp_nxt_s;
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign an          = an_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: three instances cover active-low scanning,
// leading-zero blanking and active-high polarities with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_digits, b_digits, c_digits;
  logic [3:0]  a_dpin, b_dpin, c_dpin;
  logic        a_en, b_en, c_en;
  logic [6:0]  a_seg, b_seg, c_seg;
  logic        a_dp, b_dp, c_dp;
  logic [3:0]  a_an, b_an, c_an;
  logic        a_fs, b_fs, c_fs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1),
                      .AN_ACTIVE_LOW(1), .LEAD_ZERO_BLANK(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .digits_in(a_digits), .dp_in(a_dpin), .enable(a_en),
    .seg(a_seg), .dp(a_dp), .an(a_an), .frame_start(a_fs));

  seven_seg_scanner #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1),
                      .AN_ACTIVE_LOW(1), .LEAD_ZERO_BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .digits_in(b_digits), .dp_in(b_dpin), .enable(b_en),
    .seg(b_seg), .dp(b_dp), .an(b_an), .frame_start(b_fs));

  seven_seg_scanner #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0),
                      .AN_ACTIVE_LOW(0), .LEAD_ZERO_BLANK(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .digits_in(c_digits), .dp_in(c_dpin), .enable(c_en),
    .seg(c_seg), .dp(c_dp), .an(c_an), .frame_start(c_fs));

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    a_digits = 16'h0000; b_digits = 16'h0000; c_digits = 16'h0000;
    a_dpin   = 4'h0;     b_dpin   = 4'h0;     c_dpin   = 4'h0;
    a_en     = 1'b1;     b_en     = 1'b1;     c_en     = 1'b1;
    tick();
    tick();

    check_vec("rst_an_a",  32'(a_an),  32'h0000000F);
    check_vec("rst_seg_a", 32'(a_seg), 32'h0000007F);
    check_vec("rst_dp_a",  32'(a_dp),  32'h00000001);
    check_vec("rst_fs_a",  32'(a_fs),  32'h00000000);
    check_vec("rst_an_c",  32'(c_an),  32'h00000000);
    check_vec("rst_seg_c", 32'(c_seg), 32'h00000000);

    a_digits = 16'h1234;
    b_digits = 16'h0070;
    c_digits = 16'hABCF;
    rst_n    = 1'b1;
    tick();

    for (int c = 0; c <= 148; c++) begin
      check_vec("fs_a", 32'(a_fs), (c % 32 == 0) ? 32'd1 : 32'd0);
      check_vec("lzb_hi_b", 32'(b_an[3:2]), 32'h3);
      if (c >= 64 && c <= 95) check_vec("en_off_an_a", 32'(a_an), 32'hF);
      if (c >= 96 && c <= 127)
        check_vec("dp_a", 32'(a_dp), ((c - 96) >= 18 && (c - 96) <= 23) ? 32'd0 : 32'd1);

      case (c)
        0:   begin
               check_vec("c0_an_a", 32'(a_an), 32'hF);
               check_vec("c0_an_c", 32'(c_an), 32'h0);
               check_vec("c0_seg_c", 32'(c_seg), 32'h00);
             end
        1:   check_vec("c1_an_a", 32'(a_an), 32'hF);
        2:   begin
               check_vec("c2_an_a", 32'(a_an), 32'hE);
               check_vec("c2_seg_a", 32'(a_seg), 32'b0011001);
               check_vec("c2_an_b", 32'(b_an), 32'hE);
               check_vec("c2_seg_b", 32'(b_seg), 32'b1000000);
               check_vec("c2_an_c", 32'(c_an), 32'h1);
               check_vec("c2_seg_c", 32'(c_seg), 32'h71);
             end
        7:   begin
               check_vec("c7_an_a", 32'(a_an), 32'hE);
               check_vec("c7_seg_a", 32'(a_seg), 32'b0011001);
             end
        8:   begin
               check_vec("c8_an_a", 32'(a_an), 32'hF);
               check_vec("c8_an_c", 32'(c_an), 32'h0);
               check_vec("c8_seg_c", 32'(c_seg), 32'h00);
             end
        9:   check_vec("c9_an_a", 32'(a_an), 32'hF);
        10:  begin
               check_vec("c10_an_a", 32'(a_an), 32'hD);
               check_vec("c10_seg_a", 32'(a_seg), 32'b0110000);
               check_vec("c10_an_b", 32'(b_an), 32'hD);
               check_vec("c10_seg_b", 32'(b_seg), 32'b1111000);
               check_vec("c10_an_c", 32'(c_an), 32'h2);
               check_vec("c10_seg_c", 32'(c_seg), 32'h39);
             end
        15:  begin
               check_vec("c15_an_a", 32'(a_an), 32'hD);
               check_vec("c15_seg_a", 32'(a_seg), 32'b0110000);
             end
        16:  check_vec("c16_an_a", 32'(a_an), 32'hF);
        17:  check_vec("c17_an_a", 32'(a_an), 32'hF);
        18:  begin
               check_vec("c18_an_b", 32'(b_an), 32'hF);
               check_vec("c18_an_c", 32'(c_an), 32'h4);
               check_vec("c18_seg_c", 32'(c_seg), 32'h7C);
             end
        26:  begin
               check_vec("c26_an_c", 32'(c_an), 32'h8);
               check_vec("c26_seg_c", 32'(c_seg), 32'h77);
             end
        31:  begin
               check_vec("c31_an_a", 32'(a_an), 32'h7);
               check_vec("c31_seg_a", 32'(a_seg), 32'b1111001);
             end
        34:  begin
               check_vec("c34_an_a", 32'(a_an), 32'hE);
               check_vec("c34_seg_a", 32'(a_seg), 32'b0000000);
               check_vec("c34_an_b", 32'(b_an), 32'hE);
               check_vec("c34_seg_b", 32'(b_seg), 32'b1000000);
             end
        39:  check_vec("c39_seg_a", 32'(a_seg), 32'b0000000);
        42:  check_vec("c42_an_b", 32'(b_an), 32'hF);
        114: begin
               check_vec("c114_an_a", 32'(a_an), 32'hB);
               check_vec("c114_seg_a", 32'(a_seg), 32'b0000010);
             end
        148: begin
               check_vec("c148_an_a", 32'(a_an), 32'hB);
               check_vec("c148_seg_a", 32'(a_seg), 32'b0000010);
             end
        default: ;
      endcase

      case (c)
        12:  begin
               a_digits = 16'h5678;
               b_digits = 16'h0000;
             end
        40:  a_dpin   = 4'b0100;
        63:  a_en     = 1'b0;
        95:  a_en     = 1'b1;
        140: a_digits = 16'h9ABC;
        148: rst_n    = 1'b0;
        default: ;
      endcase
      tick();
    end

    check_vec("mid_rst_an_a",  32'(a_an),  32'hF);
    check_vec("mid_rst_seg_a", 32'(a_seg), 32'h7F);
    check_vec("mid_rst_fs_a",  32'(a_fs),  32'h0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k <= 15; k++) begin
      case (k)
        0:  begin
              check_vec("rr0_fs_a", 32'(a_fs), 32'h1);
              check_vec("rr0_an_a", 32'(a_an), 32'hF);
            end
        1:  check_vec("rr1_fs_a", 32'(a_fs), 32'h0);
        2:  begin
              check_vec("rr2_an_a", 32'(a_an), 32'hE);
              check_vec("rr2_seg_a", 32'(a_seg), 32'b1000110);
            end
        10: begin
              check_vec("rr10_an_a", 32'(a_an), 32'hD);
              check_vec("rr10_seg_a", 32'(a_seg), 32'b0000011);
            end
        default: ;
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
